variable_update_dispatcher: RTL and testbench

Consumer end of the variable-chooser interface. Accepts one chosen variable (type, index) per handshake, validates it, and applies the update. Boolean variables are flipped in a local state bank. Integer and discrete variables are handed to the external proposal units with a request/done handshake. Completion, or an error, is reported as a one-cycle pulse to the sampler control.

---
 rtl/variable_update_dispatcher.sv | 186 ++++++++++++++++++
 tb/tb_variable_update_dispatcher.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/variable_update_dispatcher.sv
// -----------------------------------------------------------------------------
// variable_update_dispatcher
//
// Consumer end of the variable-chooser interface. Takes one (type, index)
// choice per handshake, validates it, then either flips a boolean in the local
// bank or hands the index to the integer/discrete proposal unit and waits for
// its done pulse (guarded by a watchdog). Every operation ends with a
// one-cycle out_update_done pulse, with out_error set when the choice was
// rejected or the proposal unit timed out.
//
// Ports
//   in_clock, in_reset        clock, asynchronous active-high reset
//   in_choice_valid           chooser presents a choice
//   out_choice_ready          dispatcher idle and able to accept
//   in_choosen_type/_index    chosen variable (0 bool, 1 int, 2 disc, 3 illegal)
//   out_int_req/out_disc_req  level requests to the proposal units
//   out_req_index             latched index, valid while a request is high
//   in_int_done/in_disc_done  one-cycle completion pulses from the units
//   out_boolean_values        current boolean bank
//   out_update_done/out_error completion pulse and its error qualifier
//   out_update_type/_index    latched choice, held between operations
// -----------------------------------------------------------------------------
module variable_update_dispatcher #(
    parameter int                  NUM_BOOL  = 2,
    parameter int                  NUM_INT   = 3,
    parameter int                  NUM_DISC  = 1,
    parameter int                  IDX_W     = 8,
    parameter int                  TIMEOUT   = 255,
    parameter logic [NUM_BOOL-1:0] BOOL_INIT = '0
) (
    input  logic                in_clock,
    input  logic                in_reset,
    input  logic                in_choice_valid,
    output logic                out_choice_ready,
    input  logic [1:0]          in_choosen_type,
    input  logic [IDX_W-1:0]    in_choosen_index,
    output logic                out_int_req,
    output logic                out_disc_req,
    output logic [IDX_W-1:0]    out_req_index,
    input  logic                in_int_done,
    input  logic                in_disc_done,
    output logic [NUM_BOOL-1:0] out_boolean_values,
    output logic                out_update_done,
    output logic                out_error,
    output logic [1:0]          out_update_type,
    output logic [IDX_W-1:0]    out_update_index
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_WAIT_INT,
        S_WAIT_DISC,
        S_DONE
    } state_t;

    // Watchdog counts 0 .. TIMEOUT-1; at least one bit even when disabled.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    // Index range checks are done on a widened copy so that a count larger
    // than 2**IDX_W, or a full-width index, still compares correctly unsigned.
    localparam int CMP_W = IDX_W + 32;
    localparam logic [CMP_W-1:0] LIM_BOOL = CMP_W'(NUM_BOOL);
    localparam logic [CMP_W-1:0] LIM_INT  = CMP_W'(NUM_INT);
    localparam logic [CMP_W-1:0] LIM_DISC = CMP_W'(NUM_DISC);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_d;
    logic                  do_flip;
    logic                  idx_legal;
    logic                  timeout_hit;
    logic [CMP_W-1:0]      idx_ext;
    logic [NUM_BOOL-1:0]   flip_mask;

    assign idx_ext       = {32'd0, out_update_index};
    assign out_req_index = out_update_index;
    assign timeout_hit   = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        idx_legal = 1'b0;
        case (out_update_type)
            2'd0:    idx_legal = (idx_ext < LIM_BOOL);
            2'd1:    idx_legal = (idx_ext < LIM_INT);
            2'd2:    idx_legal = (idx_ext < LIM_DISC);
            default: idx_legal = 1'b0;
        endcase
    end

    // One-hot mask of the boolean to invert; empty for out-of-range indices.
    always_comb begin
        flip_mask = '0;
        for (int i = 0; i < NUM_BOOL; i++) begin
            flip_mask[i] = (idx_ext == CMP_W'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = out_error;
        do_flip = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_choice_valid) state_d = S_DECODE;
            end
            S_DECODE: begin
                cnt_d = '0;
                if (!idx_legal) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    case (out_update_type)
                        2'd0: begin
                            state_d = S_DONE;
                            do_flip = 1'b1;
                        end
                        2'd1:    state_d = S_WAIT_INT;
                        default: state_d = S_WAIT_DISC;
                    endcase
                end
            end
            S_WAIT_INT: begin
                if (in_int_done) begin
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_DISC: begin
                if (in_disc_done) begin
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state and never depend combinationally on inputs.
    always_ff @(posedge in_clock or posedge in_reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (in_reset) begin
            state_q            <= S_IDLE;
            cnt_q              <= '0;
            out_error          <= 1'b0;
            out_choice_ready   <= 1'b1;
            out_int_req        <= 1'b0;
            out_disc_req       <= 1'b0;
            out_update_done    <= 1'b0;
            out_update_type    <= '0;
            out_update_index   <= '0;
            out_boolean_values <= BOOL_INIT;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            out_error        <= err_d;
            out_choice_ready <= (state_d == S_IDLE);
            out_int_req      <= (state_d == S_WAIT_INT);
            out_disc_req     <= (state_d == S_WAIT_DISC);
            out_update_done  <= (state_d == S_DONE);
            if (state_q == S_IDLE && in_choice_valid) begin
                out_update_type  <= in_choosen_type;
                out_update_index <= in_choosen_index;
            end
            if (do_flip) out_boolean_values <= out_boolean_values ^ flip_mask;
        end
    end

endmodule

// File: tb/tb_variable_update_dispatcher.sv
// -----------------------------------------------------------------------------
// Self-checking bench for variable_update_dispatcher. A transaction-level
// model turns each choice into the expected per-cycle output timeline; one
// compare process checks the DUT against it on every falling edge.
// -----------------------------------------------------------------------------
module tb_variable_update_dispatcher;

    localparam int NUM_BOOL = 2;
    localparam int NUM_INT  = 3;
    localparam int NUM_DISC = 1;
    localparam int IDX_W    = 8;
    localparam int TIMEOUT  = 5;
    typedef logic [NUM_BOOL-1:0] bank_t;
    localparam bank_t BOOL_INIT = 2'b01;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_choice_valid;
    logic             out_choice_ready;
    logic [1:0]       in_choosen_type;
    logic [IDX_W-1:0] in_choosen_index;
    logic             out_int_req;
    logic             out_disc_req;
    logic [IDX_W-1:0] out_req_index;
    logic             in_int_done;
    logic             in_disc_done;
    bank_t            out_boolean_values;
    logic             out_update_done;
    logic             out_error;
    logic [1:0]       out_update_type;
    logic [IDX_W-1:0] out_update_index;

    variable_update_dispatcher #(
        .NUM_BOOL (NUM_BOOL),
        .NUM_INT  (NUM_INT),
        .NUM_DISC (NUM_DISC),
        .IDX_W    (IDX_W),
        .TIMEOUT  (TIMEOUT),
        .BOOL_INIT(BOOL_INIT)
    ) dut (
        .in_clock          (clk),
        .in_reset          (rst),
        .in_choice_valid   (in_choice_valid),
        .out_choice_ready  (out_choice_ready),
        .in_choosen_type   (in_choosen_type),
        .in_choosen_index  (in_choosen_index),
        .out_int_req       (out_int_req),
        .out_disc_req      (out_disc_req),
        .out_req_index     (out_req_index),
        .in_int_done       (in_int_done),
        .in_disc_done      (in_disc_done),
        .out_boolean_values(out_boolean_values),
        .out_update_done   (out_update_done),
        .out_error         (out_error),
        .out_update_type   (out_update_type),
        .out_update_index  (out_update_index)
    );

    always #5 clk = ~clk;

    // Expected outputs for the current cycle.
    logic             e_ready, e_ireq, e_dreq, e_done, e_err;
    bank_t            e_bools;
    logic [1:0]       e_type;
    logic [IDX_W-1:0] e_idx;
    bit               chk_en = 1'b0;

    int n_vec      = 0;
    int n_fail     = 0;
    int req_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready",  32'(out_choice_ready),   32'(e_ready));
            check("int_req", 32'(out_int_req),       32'(e_ireq));
            check("disc_req", 32'(out_disc_req),     32'(e_dreq));
            check("done",   32'(out_update_done),    32'(e_done));
            check("error",  32'(out_error),          32'(e_err));
            check("bools",  32'(out_boolean_values), 32'(e_bools));
            check("upd_type", 32'(out_update_type),  32'(e_type));
            check("upd_index", 32'(out_update_index), 32'(e_idx));
            if (e_ireq || e_dreq) check("req_index", 32'(out_req_index), 32'(e_idx));
            if (out_int_req || out_disc_req) req_cycles++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        e_ready = 1'b1;
        e_ireq  = 1'b0;
        e_dreq  = 1'b0;
        e_done  = 1'b0;
        e_err   = 1'b0;
    endtask

    // noise: 0 = quiet, 1 = random, 2 = always high on the ignored done line.
    function automatic logic noise_bit(input int noise);
        if (noise == 2) return 1'b1;
        if (noise == 1) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    // One complete operation starting from an idle cycle. done_after is the
    // number of request-high cycles before the unit answers; 0 or anything
    // beyond TIMEOUT means the unit never answers.
    task automatic run_txn(input logic [1:0] t, input logic [IDX_W-1:0] idx,
                           input int done_after, input int noise);
        bit legal, tmo;
        int n;
        legal = (t == 2'd0 && int'(idx) < NUM_BOOL) ||
                (t == 2'd1 && int'(idx) < NUM_INT)  ||
                (t == 2'd2 && int'(idx) < NUM_DISC);
        in_choice_valid  = 1'b1;
        in_choosen_type  = t;
        in_choosen_index = idx;
        in_int_done      = noise_bit(noise);
        in_disc_done     = noise_bit(noise);
        tick();                                   // accept edge
        in_choice_valid  = 1'b0;
        in_choosen_type  = 2'($urandom);
        in_choosen_index = IDX_W'($urandom);
        in_int_done      = noise_bit(noise);
        in_disc_done     = noise_bit(noise);
        e_ready = 1'b0;
        e_type  = t;
        e_idx   = idx;
        tick();                                   // decode exit edge
        if (!legal || t == 2'd0) begin
            if (legal) e_bools = e_bools ^ (bank_t'(1) << idx);
            e_done = 1'b1;
            e_err  = !legal;
            in_int_done  = noise_bit(noise);
            in_disc_done = noise_bit(noise);
            tick();
        end else begin
            tmo = (done_after < 1) || (done_after > TIMEOUT);
            n   = tmo ? TIMEOUT : done_after;
            if (t == 2'd1) e_ireq = 1'b1;
            else           e_dreq = 1'b1;
            for (int k = 1; k <= n; k++) begin
                if (t == 2'd1) begin
                    in_int_done  = (k == n) && !tmo;
                    in_disc_done = noise_bit(noise);
                end else begin
                    in_disc_done = (k == n) && !tmo;
                    in_int_done  = noise_bit(noise);
                end
                tick();
            end
            e_ireq = 1'b0;
            e_dreq = 1'b0;
            e_done = 1'b1;
            e_err  = tmo;
            in_int_done  = noise_bit(noise);
            in_disc_done = noise_bit(noise);
            tick();
        end
        set_idle();
        in_int_done  = 1'b0;
        in_disc_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst              = 1'b1;
        in_choice_valid  = 1'b0;
        in_choosen_type  = '0;
        in_choosen_index = '0;
        in_int_done      = 1'b0;
        in_disc_done     = 1'b0;
        set_idle();
        e_bools = BOOL_INIT;
        e_type  = '0;
        e_idx   = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(out_choice_ready), 32'd1);
        check("rst_bools", 32'(out_boolean_values), 32'h1);
        check("rst_done",  32'(out_update_done), 32'd0);
        check("rst_index", 32'(out_update_index), 32'd0);
        rst = 1'b0;
        tick();
        chk_en = 1'b1;

        // Boolean flip of index 1 from 2'b01.
        run_txn(2'd0, 8'd1, 0, 0);
        check("bool_flip", 32'(out_boolean_values), 32'h3);

        // Integer index 2, done after 4 request cycles.
        req_cycles = 0;
        run_txn(2'd1, 8'd2, 4, 0);
        check("int_req_len", 32'(req_cycles), 32'd4);
        check("int_type", 32'(out_update_type), 32'd1);
        check("int_index", 32'(out_update_index), 32'd2);

        // Illegal choices: out-of-range discrete and type 3.
        req_cycles = 0;
        run_txn(2'd2, 8'd1, 0, 0);
        run_txn(2'd3, 8'd0, 0, 0);
        check("illegal_noreq", 32'(req_cycles), 32'd0);
        check("illegal_bools", 32'(out_boolean_values), 32'h3);

        // Discrete timeout, then a late done that must be ignored.
        req_cycles = 0;
        run_txn(2'd2, 8'd0, 0, 0);
        check("tmo_req_len", 32'(req_cycles), 32'd5);
        in_disc_done = 1'b1;
        tick();
        in_disc_done = 1'b0;
        tick();
        check("late_done", 32'(out_update_done), 32'd0);

        // Integer done during WAIT_DISC and in IDLE is ignored.
        in_int_done = 1'b1;
        tick();
        in_int_done = 1'b0;
        run_txn(2'd2, 8'd0, 3, 2);

        // Minimum latency: answer on the first request cycle.
        run_txn(2'd1, 8'd0, 1, 1);
        run_txn(2'd2, 8'd0, 1, 2);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            logic [IDX_W-1:0] ridx;
            repeat ($urandom_range(0, 2)) begin
                in_int_done  = 1'($urandom_range(0, 1));
                in_disc_done = 1'($urandom_range(0, 1));
                tick();
            end
            ridx = ($urandom_range(0, 7) == 0) ? IDX_W'($urandom) : IDX_W'($urandom_range(0, 3));
            run_txn(2'($urandom_range(0, 3)), ridx, $urandom_range(0, 7), $urandom_range(0, 2));
        end

        // Asynchronous reset in the middle of WAIT_INT.
        run_txn(2'd0, 8'd1, 0, 0);
        in_choice_valid  = 1'b1;
        in_choosen_type  = 2'd1;
        in_choosen_index = 8'd1;
        tick();
        in_choice_valid = 1'b0;
        e_ready = 1'b0;
        e_type  = 2'd1;
        e_idx   = 8'd1;
        tick();
        e_ireq = 1'b1;
        tick();
        chk_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_req",   32'(out_int_req), 32'd0);
        check("mid_rst_ready", 32'(out_choice_ready), 32'd1);
        check("mid_rst_bools", 32'(out_boolean_values), 32'h1);
        check("mid_rst_type",  32'(out_update_type), 32'd0);
        check("mid_rst_done",  32'(out_update_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_idle();
        e_bools = BOOL_INIT;
        e_type  = '0;
        e_idx   = '0;
        tick();
        chk_en = 1'b1;
        in_int_done = 1'b1;
        tick();
        in_int_done = 1'b0;
        tick();
        tick();
        check("post_rst_done", 32'(out_update_done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
